// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: decimates the codec capture stream into a single
// FRAME_LEN-deep buffer, then streams the frame to the FFT Avalon-ST sink
// as one packet framed by sop/eop. Kept samples that arrive while a frame
// is being streamed are dropped and latched into a sticky overrun flag.
//
// Handshake: a word moves when sink_valid && sink_ready (readyLatency 0).
// Once sink_valid rises, it and sink_real/sop/eop are held unchanged until
// that transfer happens; valid is never withdrawn before its transfer.
module fft_frame_sequencer #(
  parameter int FRAME_LEN = 1024,
  parameter int DECIM     = 4,
  parameter int SAMPLE_W  = 24,
  localparam int AW       = $clog2(FRAME_LEN)
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                enable,
  input  logic                audio_in_available,
  input  logic [31:0]         left_channel_audio_in,
  input  logic                sink_ready,
  output logic                sink_valid,
  output logic                sink_sop,
  output logic                sink_eop,
  output logic [SAMPLE_W-1:0] sink_real,
  output logic [SAMPLE_W-1:0] sink_imag,
  output logic [1:0]          sink_error,
  output logic [AW:0]         fftpts_in,
  output logic                busy,
  output logic                overrun,
  output logic [15:0]         frame_count,
  output logic [1:0]          dbg_state
);

  localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [AW-1:0]       wr_idx_q, wr_idx_d;
  logic [AW-1:0]       rd_idx_q, rd_idx_d;
  logic [DCW-1:0]      dcnt_q, dcnt_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;
  logic [15:0]         frame_count_q, frame_count_d;
  logic                busy_q;
  logic                kept;
  logic                xfer;
  logic                we;
  logic [SAMPLE_W-1:0] sample;
  logic [SAMPLE_W-1:0] rdata_q;
  logic [SAMPLE_W-1:0] mem [FRAME_LEN];

  assign sample = left_channel_audio_in[31 -: SAMPLE_W];
  assign kept   = audio_in_available && (dcnt_q == '0);
  assign xfer   = valid_q && sink_ready;

  // Low codec bits below the FFT input width are truncated away on purpose.
  if (SAMPLE_W < 32) begin : g_trunc
    logic unused_low_bits;
    assign unused_low_bits = ^left_channel_audio_in[31-SAMPLE_W:0];
  end

  // Next-state logic: decimation, buffer fill, packet streaming, overrun.
  always_comb begin
    state_d       = state_q;
    wr_idx_d      = wr_idx_q;
    rd_idx_d      = rd_idx_q;
    dcnt_d        = dcnt_q;
    valid_d       = valid_q;
    overrun_d     = overrun_q;
    frame_count_d = frame_count_q;
    we            = 1'b0;

    if ((state_q != S_IDLE) && audio_in_available) begin
      dcnt_d = (dcnt_q == DCW'(DECIM - 1)) ? '0 : dcnt_q + DCW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d   = S_FILL;
          wr_idx_d  = '0;
          dcnt_d    = '0;
          overrun_d = 1'b0;
        end
      end
      S_FILL: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (kept) begin
          we       = 1'b1;
          wr_idx_d = wr_idx_q + AW'(1);
          if (wr_idx_q == AW'(FRAME_LEN - 1)) begin
            state_d  = S_STREAM;
            rd_idx_d = '0;
            valid_d  = 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (kept) overrun_d = 1'b1;
        if (xfer) begin
          rd_idx_d = rd_idx_q + AW'(1);
          if (rd_idx_q == AW'(FRAME_LEN - 1)) begin
            valid_d       = 1'b0;
            frame_count_d = frame_count_q + 16'd1;
            if (enable) begin
              state_d  = S_FILL;
              wr_idx_d = '0;
              dcnt_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers; reset drops any frame in flight without an eop.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wr_idx_q      <= '0;
      rd_idx_q      <= '0;
      dcnt_q        <= '0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
      frame_count_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      dcnt_q        <= dcnt_d;
      valid_q       <= valid_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
      busy_q        <= (state_q != S_IDLE);
    end
  end

  // Frame RAM; the read uses the next read index so the output register
  // already holds the word being presented and stays put while stalled.
  always_ff @(posedge CLOCK_50) begin
    if (we) mem[wr_idx_q] <= sample;
    rdata_q <= mem[rd_idx_d];
  end

  assign sink_valid  = valid_q;
  assign sink_sop    = valid_q && (rd_idx_q == '0);
  assign sink_eop    = valid_q && (rd_idx_q == AW'(FRAME_LEN - 1));
  assign sink_real   = valid_q ? rdata_q : '0;
  assign sink_imag   = '0;
  assign sink_error  = 2'b00;
  assign fftpts_in   = (AW + 1)'(FRAME_LEN);
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign frame_count = frame_count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with a 64-sample frame and 4:1
// decimation. A negedge monitor records every transfer as {sop,eop,data}
// and checks that a stalled word is held; each test builds its expected
// frame in exp_q and compares it against the recorded transfers.
module tb_fft_frame_sequencer;

  localparam int FL = 64;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        strobe;
  logic [31:0] audio;
  logic        ready;
  logic        sink_valid, sink_sop, sink_eop;
  logic [23:0] sink_real, sink_imag;
  logic [1:0]  sink_error;
  logic [6:0]  fftpts_in;
  logic        busy, overrun;
  logic [15:0] frame_count;
  logic [1:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int sop_cyc = 0;
  int eop_cyc = 0;
  bit rand_ready = 1'b0;
  logic [25:0] got_q[$];
  logic [25:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [25:0] prev_word;

  fft_frame_sequencer #(.FRAME_LEN(FL), .DECIM(4), .SAMPLE_W(24)) u_dut (
    .CLOCK_50(clk), .reset(rst), .enable(enable),
    .audio_in_available(strobe), .left_channel_audio_in(audio),
    .sink_ready(ready), .sink_valid(sink_valid), .sink_sop(sink_sop),
    .sink_eop(sink_eop), .sink_real(sink_real), .sink_imag(sink_imag),
    .sink_error(sink_error), .fftpts_in(fftpts_in), .busy(busy),
    .overrun(overrun), .frame_count(frame_count), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required test sequence end");
    $fatal(1, "watchdog");
  end

  // monitor: record transfers, check hold while stalled
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        vectors++;
        if (sink_valid !== 1'b1 || {sink_sop, sink_eop, sink_real} !== prev_word) begin
          miscompares++;
          $display("FAIL stall_hold: valid=%b word=%h, required valid=1 word=%h",
                   sink_valid, {sink_sop, sink_eop, sink_real}, prev_word);
        end
      end
      if (sink_valid && ready) begin
        got_q.push_back({sink_sop, sink_eop, sink_real});
        if (sink_sop) sop_cyc = cyc;
        if (sink_eop) eop_cyc = cyc;
      end
      prev_stall = sink_valid && !ready;
      prev_word  = {sink_sop, sink_eop, sink_real};
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [23:0] v);
    strobe = 1'b1;
    audio  = {v, 8'($urandom_range(0, 255))};
    tick();
    strobe = 1'b0;
  endtask

  // 256 strobes; only every 4th is kept. ramp=1 puts k on kept strobe 4k and
  // junk elsewhere, ramp=0 puts the strobe number on every strobe.
  task automatic fill_frame(input bit ramp);
    for (int i = 0; i < 256; i++) begin
      send(ramp ? ((i % 4 == 0) ? 24'(i / 4) : 24'hA5A5A5) : 24'(i));
      if (i == 253) begin
        vectors++;
        if (sink_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL first_valid: sink_valid=%b, required 1", sink_valid);
        end
      end
    end
  endtask

  task automatic wait_xfers(input int n, input int budget);
    int c = 0;
    while (got_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    vectors++;
    if (got_q.size() < n) begin
      miscompares++;
      $display("FAIL xfer_timeout: got %0d transfers, required %0d", got_q.size(), n);
    end
  endtask

  task automatic build_exp(input bit ramp);
    exp_q.delete();
    for (int k = 0; k < FL; k++)
      exp_q.push_back({(k == 0), (k == FL - 1), (ramp ? 24'(k) : 24'(4 * k))});
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; strobe = 1'b0; audio = '0; ready = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({sink_valid, sink_sop, sink_eop, busy, overrun} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: v/s/e/busy/ovr=%b, required 00000",
               {sink_valid, sink_sop, sink_eop, busy, overrun});
    end
    vectors++;
    if (sink_real !== 24'd0 || frame_count !== 16'd0 || dbg_state !== ST_IDLE) begin
      miscompares++;
      $display("FAIL reset_values: real=%h count=%0d state=%0d, required 0 0 0",
               sink_real, frame_count, dbg_state);
    end
    vectors++;
    if (fftpts_in !== 7'd64 || sink_imag !== 24'd0 || sink_error !== 2'd0) begin
      miscompares++;
      $display("FAIL constants: fftpts=%0d imag=%h err=%0d, required 64 0 0",
               fftpts_in, sink_imag, sink_error);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_idle_strobe();
    got_q.delete();
    enable = 1'b0; ready = 1'b1;
    for (int i = 0; i < 20; i++) send(24'h123456);
    repeat (3) tick();
    vectors++;
    if (got_q.size() != 0 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      miscompares++;
      $display("FAIL idle_strobe: xfers=%0d busy=%b state=%0d, required 0 0 0",
               got_q.size(), busy, dbg_state);
    end
  endtask

  task automatic test_basic_frame();
    got_q.delete();
    ready = 1'b1; enable = 1'b1;
    repeat (2) tick();
    vectors++;
    if (busy !== 1'b1 || dbg_state !== ST_FILL) begin
      miscompares++;
      $display("FAIL fill_entry: busy=%b state=%0d, required 1 1", busy, dbg_state);
    end
    fill_frame(1'b1);
    wait_xfers(FL, 200);
    repeat (2) tick();
    build_exp(1'b1);
    vectors++;
    if (got_q.size() != FL) begin
      miscompares++;
      $display("FAIL basic_count: got %0d transfers, required %0d", got_q.size(), FL);
    end
    for (int k = 0; k < FL && k < got_q.size(); k++) begin
      vectors++;
      if (got_q[k] !== exp_q[k]) begin
        miscompares++;
        $display("FAIL basic_word[%0d]: got %h, required %h", k, got_q[k], exp_q[k]);
      end
    end
    vectors++;
    if (eop_cyc - sop_cyc != FL - 1) begin
      miscompares++;
      $display("FAIL throughput: sop..eop spans %0d cycles, required %0d",
               eop_cyc - sop_cyc, FL - 1);
    end
    vectors++;
    if (frame_count !== 16'd1 || dbg_state !== ST_FILL || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_after: count=%0d state=%0d busy=%b, required 1 1 1",
               frame_count, dbg_state, busy);
    end
    enable = 1'b0;
    repeat (3) tick();
    vectors++;
    if (dbg_state !== ST_IDLE || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_idle: state=%0d busy=%b, required 0 0", dbg_state, busy);
    end
  endtask

  task automatic test_decimation();
    got_q.delete();
    ready = 1'b1; enable = 1'b1;
    tick();
    fill_frame(1'b0);
    enable = 1'b0;
    wait_xfers(FL, 200);
    repeat (3) tick();
    build_exp(1'b0);
    vectors++;
    if (got_q.size() != FL) begin
      miscompares++;
      $display("FAIL decim_count: got %0d transfers, required %0d", got_q.size(), FL);
    end
    for (int k = 0; k < FL && k < got_q.size(); k++) begin
      vectors++;
      if (got_q[k] !== exp_q[k]) begin
        miscompares++;
        $display("FAIL decim_word[%0d]: got %h, required %h", k, got_q[k], exp_q[k]);
      end
    end
    vectors++;
    if (frame_count !== 16'd2 || dbg_state !== ST_IDLE || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL decim_after: count=%0d state=%0d busy=%b, required 2 0 0",
               frame_count, dbg_state, busy);
    end
  endtask

  task automatic test_backpressure();
    got_q.delete();
    rand_ready = 1'b1; enable = 1'b1;
    tick();
    fill_frame(1'b0);
    enable = 1'b0;
    wait_xfers(FL, 1000);
    rand_ready = 1'b0; ready = 1'b1;
    repeat (3) tick();
    build_exp(1'b0);
    vectors++;
    if (got_q.size() != FL) begin
      miscompares++;
      $display("FAIL bp_count: got %0d transfers, required %0d", got_q.size(), FL);
    end
    for (int k = 0; k < FL && k < got_q.size(); k++) begin
      vectors++;
      if (got_q[k] !== exp_q[k]) begin
        miscompares++;
        $display("FAIL bp_word[%0d]: got %h, required %h", k, got_q[k], exp_q[k]);
      end
    end
    vectors++;
    if (frame_count !== 16'd3) begin
      miscompares++;
      $display("FAIL bp_frames: count=%0d, required 3", frame_count);
    end
  endtask

  task automatic test_overrun();
    got_q.delete();
    ready = 1'b0; enable = 1'b1;
    tick();
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_start: overrun=%b, required 0", overrun);
    end
    fill_frame(1'b0);
    for (int i = 256; i < 260; i++) begin
      send(24'(i));
      if (i == 256) begin
        vectors++;
        if (overrun !== 1'b1) begin
          miscompares++;
          $display("FAIL ovr_set: overrun=%b, required 1", overrun);
        end
      end
    end
    vectors++;
    if ({sink_valid, sink_sop, sink_eop, sink_real} !== {3'b110, 24'd0}) begin
      miscompares++;
      $display("FAIL ovr_hold: v/s/e/real=%b%b%b/%h, required 110/000000",
               sink_valid, sink_sop, sink_eop, sink_real);
    end
    enable = 1'b0; ready = 1'b1;
    wait_xfers(FL, 200);
    repeat (3) tick();
    build_exp(1'b0);
    vectors++;
    if (got_q.size() != FL) begin
      miscompares++;
      $display("FAIL ovr_count: got %0d transfers, required %0d", got_q.size(), FL);
    end
    for (int k = 0; k < FL && k < got_q.size(); k++) begin
      vectors++;
      if (got_q[k] !== exp_q[k]) begin
        miscompares++;
        $display("FAIL ovr_word[%0d]: got %h, required %h", k, got_q[k], exp_q[k]);
      end
    end
    vectors++;
    if (overrun !== 1'b1 || frame_count !== 16'd4) begin
      miscompares++;
      $display("FAIL ovr_sticky: overrun=%b count=%0d, required 1 4", overrun, frame_count);
    end
    enable = 1'b1;
    tick();
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_clear: overrun=%b, required 0", overrun);
    end
    enable = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_enable_drop_fill();
    got_q.delete();
    ready = 1'b1; enable = 1'b1;
    tick();
    for (int i = 0; i < 40; i++) send(24'(i));
    enable = 1'b0;
    tick();
    vectors++;
    if (dbg_state !== ST_IDLE) begin
      miscompares++;
      $display("FAIL drop_fill_state: state=%0d, required 0", dbg_state);
    end
    repeat (80) tick();
    vectors++;
    if (got_q.size() != 0 || sink_valid !== 1'b0 || busy !== 1'b0 || frame_count !== 16'd4) begin
      miscompares++;
      $display("FAIL drop_fill_quiet: xfers=%0d valid=%b busy=%b count=%0d, required 0 0 0 4",
               got_q.size(), sink_valid, busy, frame_count);
    end
  endtask

  task automatic test_enable_drop_stream();
    got_q.delete();
    ready = 1'b1; enable = 1'b1;
    tick();
    fill_frame(1'b1);
    wait_xfers(20, 100);
    enable = 1'b0;
    wait_xfers(FL, 200);
    repeat (3) tick();
    build_exp(1'b1);
    vectors++;
    if (got_q.size() != FL) begin
      miscompares++;
      $display("FAIL drop_str_count: got %0d transfers, required %0d", got_q.size(), FL);
    end
    for (int k = 0; k < FL && k < got_q.size(); k++) begin
      vectors++;
      if (got_q[k] !== exp_q[k]) begin
        miscompares++;
        $display("FAIL drop_str_word[%0d]: got %h, required %h", k, got_q[k], exp_q[k]);
      end
    end
    vectors++;
    if (frame_count !== 16'd5 || dbg_state !== ST_IDLE || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_str_after: count=%0d state=%0d busy=%b, required 5 0 0",
               frame_count, dbg_state, busy);
    end
  endtask

  task automatic test_reset_mid_stream();
    got_q.delete();
    ready = 1'b1; enable = 1'b1;
    tick();
    fill_frame(1'b0);
    wait_xfers(30, 100);
    rst = 1'b1;
    #1;
    vectors++;
    if ({sink_valid, sink_sop, sink_eop, busy, overrun} !== 5'b0 || sink_real !== 24'd0 ||
        frame_count !== 16'd0 || dbg_state !== ST_IDLE) begin
      miscompares++;
      $display("FAIL reset_mid: v/s/e/busy/ovr=%b real=%h count=%0d state=%0d, required 00000 0 0 0",
               {sink_valid, sink_sop, sink_eop, busy, overrun}, sink_real, frame_count, dbg_state);
    end
    repeat (2) tick();
    rst = 1'b0;
    got_q.delete();
    tick();
    fill_frame(1'b1);
    vectors++;
    if (frame_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_count_hold: count=%0d, required 0", frame_count);
    end
    enable = 1'b0;
    wait_xfers(FL, 200);
    repeat (3) tick();
    build_exp(1'b1);
    vectors++;
    if (got_q.size() != FL) begin
      miscompares++;
      $display("FAIL reset_count: got %0d transfers, required %0d", got_q.size(), FL);
    end
    for (int k = 0; k < FL && k < got_q.size(); k++) begin
      vectors++;
      if (got_q[k] !== exp_q[k]) begin
        miscompares++;
        $display("FAIL reset_word[%0d]: got %h, required %h", k, got_q[k], exp_q[k]);
      end
    end
    vectors++;
    if (frame_count !== 16'd1) begin
      miscompares++;
      $display("FAIL reset_frames: count=%0d, required 1", frame_count);
    end
  endtask

  // sequence and report
  initial begin
    test_reset();
    test_idle_strobe();
    test_basic_frame();
    test_decimation();
    test_backpressure();
    test_overrun();
    test_enable_drop_fill();
    test_enable_drop_stream();
    test_reset_mid_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

Sequences captured codec samples into fixed-length frames for the tuner FFT core. Sits between the Audio_Controller capture side (`audio_in_available` / `left_channel_audio_in`) and the FFT Avalon-ST sink. It decimates the 48 kHz stream, fills a single frame buffer, then streams the frame as one packet with sop/eop. It also flags any sample lost while a frame is being streamed.

## Interface
Parameters:
- `FRAME_LEN`, 1024: samples per FFT frame; power of two, 64..4096.
- `DECIM`, 4: keep 1 of every DECIM input strobes; 1..16.
- `SAMPLE_W`, 24: width of the FFT real/imag inputs; 8..32.

Ports (`AW` = log2(FRAME_LEN)):
- `CLOCK_50` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: level; allows frame capture.
- `audio_in_available` in 1: one-cycle-or-longer strobe; each high cycle counts as one sample.
- `left_channel_audio_in` in 32: signed codec sample, valid while the strobe is high.
- `sink_ready` in 1: FFT ready (readyLatency 0).
- `sink_valid` out 1: frame sample valid.
- `sink_sop` out 1: first sample of the packet.
- `sink_eop` out 1: last sample of the packet.
- `sink_real` out SAMPLE_W: `left_channel_audio_in[31:32-SAMPLE_W]`.
- `sink_imag` out SAMPLE_W: constant 0.
- `sink_error` out 2: constant 0.
- `fftpts_in` out AW+1: constant FRAME_LEN.
- `busy` out 1: high in FILL or STREAM.
- `overrun` out 1: sticky; a kept sample was dropped.
- `frame_count` out 16: completed frames, wraps at 65535 to 0.

## Operation
- Buffer: FRAME_LEN x SAMPLE_W synchronous RAM. Write pointer `wr_idx` and read pointer `rd_idx` are each AW bits.
- Decimation counter `dcnt` (0..DECIM-1) advances on every strobe cycle in FILL and STREAM. A strobe with `dcnt==0` is a "kept" sample. `dcnt` clears on entry to FILL.
- IDLE:
  - Outputs quiescent.
  - `enable`=1 goes to FILL. `wr_idx`=0, `dcnt`=0, `overrun` cleared on this rising transition.
- FILL:
  - Each kept sample writes `mem[wr_idx]` and increments `wr_idx`.
  - The write with `wr_idx==FRAME_LEN-1` moves to STREAM next cycle. `rd_idx`=0.
  - `enable`=0 goes to IDLE and discards the partial frame.
- STREAM:
  - RAM read is prefetched into an output register; `sink_valid` is high while that register holds data.
  - A transfer happens when `sink_valid && sink_ready`. On a transfer, `rd_idx` advances and the next word is presented.
  - `sink_sop`=1 only with index 0; `sink_eop`=1 only with index FRAME_LEN-1.
  - On the eop transfer, `frame_count`+1. Next state is FILL if `enable`=1 (`wr_idx`=0, `dcnt`=0); otherwise IDLE.
  - `enable` dropping mid-STREAM never truncates the packet; the frame completes, then the block goes to IDLE.
  - A kept sample arriving in STREAM is dropped and sets `overrun`. No buffer write occurs.
- `sink_real` is truncation of the top SAMPLE_W bits, no rounding. `sink_imag`, `sink_error` and `fftpts_in` are constants.

## Timing
- Reset values:
  - state IDLE; `sink_valid`, `sink_sop`, `sink_eop`=0; `sink_real`=0.
  - `busy`=0, `overrun`=0, `frame_count`=0.
  - `wr_idx`=0, `rd_idx`=0, `dcnt`=0.
- Reset mid-frame drops the frame immediately; no eop is issued. The FFT is reset from the same source.
- FILL→STREAM: first `sink_valid` no later than 2 cycles after the last buffer write.
- Throughput: one sample per cycle while `sink_ready`=1. A frame streams in FRAME_LEN cycles after first valid when ready is held high.
- While `sink_ready`=0, `sink_valid` and data/sop/eop are held stable.
- `sink_valid` never drops before its transfer.
- Strobe held high for N cycles = N samples. Strobe during IDLE is ignored.
- `busy` is registered and follows the state one cycle after the transition edge.
- `overrun` sets the cycle after the offending strobe.

## Test plan
- **Basic frame:** FRAME_LEN=64, DECIM=1, `sink_ready`=1, strobe ramp 0..63 in bits [31:8] → one packet, `sink_real`=0..63, sop on 0, eop on 63, `frame_count`=1.
- **Decimation:** DECIM=4, 256 strobes carrying value i → buffer holds 0,4,8..252; 64 transfers.
- **Backpressure:** random `sink_ready` 50% → data/sop/eop stable while stalled; exactly 64 transfers in order; no duplicates or gaps.
- **Overrun:** `sink_ready`=0 during STREAM while kept strobes arrive → `overrun`=1; frame still streams original data once ready; `overrun` clears on next `enable` 0→1.
- **Enable drop:**
  - Mid-FILL → IDLE, no `sink_valid`.
  - Mid-STREAM → packet completes with eop, then IDLE, `busy`=0.
- **Reset mid-STREAM:** `reset` at transfer 30 → all outputs 0 immediately; after release with `enable`=1, next packet starts at sop; `frame_count`=0 until its eop.
